assoc_cache_ctrl: RTL and testbench
===================================

Name: assoc_cache_ctrl

Overview:
- Parametrised 2-way set-associative, read-only block cache with LRU replacement, sitting between the address-generating front end and the word-wide main memory model.
- Successor to the fixed direct-mapped 15-bit cache: generalised address, data, index and block widths.
- Adds valid/ready handshakes, multi-word refill with memory backpressure, bulk flush and hit/access statistics.

Parameters:
- ADDR_W, 15, word address width.
- DATA_W, 32, data word width.
- INDEX_W, 10, set index bits; 2^INDEX_W sets.
- OFFSET_W, 2, word-in-block bits; BLK = 2^OFFSET_W words per block.
- CNT_W, 16, statistics counter width.
- Derived: TAG_W = ADDR_W-INDEX_W-OFFSET_W (3 at defaults, must be >=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  lookup request.
- req_ready  out  1  request accepted when high with req_valid.
- req_addr  in  ADDR_W  {tag,index,offset}.
- resp_valid  out  1  one-cycle response pulse, no backpressure.
- resp_data  out  DATA_W  requested word.
- resp_hit  out  1  1 = hit, 0 = serviced by refill.
- mem_req_valid  out  1  memory word read request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  word address requested.
- mem_resp_valid  in  1  memory read data valid.
- mem_resp_data  in  DATA_W  memory read data.
- flush  in  1  level request to invalidate all lines.
- busy  out  1  high in any state except IDLE.
- hit_count  out  CNT_W  saturating hit counter.
- access_count  out  CNT_W  saturating response counter.

Behaviour:
- Reset (rst=0, async): state IDLE; all valid and LRU bits cleared; counters 0; resp_valid, resp_hit, mem_req_valid 0; resp_data 0. Data/tag arrays not reset.
- Reset mid-refill aborts: mem_req_valid drops immediately. Any later mem_resp_valid is ignored until a new request reaches WAIT.
- req_ready = (state==IDLE) && !flush, combinational. busy = (state!=IDLE).
- States: IDLE, LOOKUP, MREQ, MWAIT, RESP, FLUSH.
- IDLE:
  - flush=1 -> FLUSH. Flush has priority over a same-cycle req_valid; that request is not accepted.
  - Otherwise req_valid -> latch req_addr, go to LOOKUP.
- LOOKUP (1 cycle): compare the tag against both ways of the set.
  - Hit in way w -> RESP with resp_hit=1, data from way w; lru[set] = ~w.
  - Miss -> select victim: invalid way0, else invalid way1, else way lru[set]. Word counter = 0; go to MREQ.
- MREQ:
  - mem_req_valid=1, mem_req_addr = {tag,index,word counter}.
  - Address is stable while mem_req_ready=0.
  - On mem_req_ready -> MWAIT.
- MWAIT:
  - mem_req_valid=0; at most one outstanding memory read.
  - On mem_resp_valid, write the word into the victim at the counter position.
  - If counter == BLK-1: set valid, write tag, lru[set] = ~victim, go to RESP with resp_hit=0 and data = refilled word at the requested offset.
  - Otherwise increment counter and return to MREQ.
  - Words are always fetched in order 0..BLK-1.
- RESP (1 cycle): resp_valid=1.
  - access_count += 1; hit_count += resp_hit.
  - Both counters saturate at all-ones.
  - Then go to IDLE.
- Latency:
  - Hit: accept edge E0 -> resp_valid high in the cycle after edge E2.
  - Miss with zero-wait memory: 2 + 2*BLK + 1 edges.
- FLUSH:
  - Clears valid and LRU of one set per cycle, index 0 .. 2^INDEX_W-1, then returns to IDLE.
  - flush is sampled only in IDLE. If asserted while busy, it is taken on return to IDLE if still high. If still high after completion, another flush runs.
  - Counters are unaffected.
- mem_resp_valid outside MWAIT is ignored. mem_req_ready outside MREQ is ignored.

Test Plan:
- Cold miss:
  - Stimulus: reset; memory returns data = address; read 0x0012.
  - Required: 4 mem requests 0x0010..0x0013 in order; resp_data=0x12, resp_hit=0; access_count=1, hit_count=0.
- Hit:
  - Stimulus: read 0x0011.
  - Required: resp_valid 2 edges after acceptance; data 0x11, resp_hit=1, no memory traffic; hit_count=1.
- LRU conflict:
  - Stimulus: read tags 0,1 at index 4 (0x0010, 0x1010), then 0x0010, then 0x2010, then 0x1010.
  - Required: 0x2010 evicts tag 1; final 0x1010 misses; 0x0010 re-read hits.
- Memory backpressure:
  - Stimulus: hold mem_req_ready=0 for 5 cycles on each word.
  - Required: mem_req_addr stable throughout; correct refill; resp after all 4 words.
- Flush:
  - Stimulus: assert flush together with req_valid.
  - Required: request not accepted; busy for 1024 cycles; previously hitting address then misses; counters unchanged.
- Reset mid-refill and saturation:
  - Stimulus: drop rst in MWAIT, then pulse mem_resp_valid.
  - Required: IDLE, no write, line invalid.
  - Stimulus: with CNT_W=2, issue 5 hits.
  - Required: both counters hold 3.

Source files
------------

// File: rtl/assoc_cache_ctrl_if.sv
// Request/response and memory-side handshake bundle for the set-associative cache.
interface assoc_cache_ctrl_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_hit;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  modport slave (
    input  req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
    output req_ready, resp_valid, resp_data, resp_hit, mem_req_valid, mem_req_addr
  );

  modport master (
    output req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  req_ready, resp_valid, resp_data, resp_hit, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/assoc_cache_ctrl.sv
// 2-way set-associative read-only block cache, LRU replacement, in-order
// multi-word refill with one outstanding memory read, bulk flush and statistics.
module assoc_cache_ctrl #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 10,
  parameter int OFFSET_W = 2,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  assoc_cache_ctrl_if.slave    bus,
  input  logic                 flush,
  output logic                 busy,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     access_count
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int SETS  = 1 << INDEX_W;
  localparam int BLK   = 1 << OFFSET_W;
  localparam logic [CNT_W-1:0]    CNT_ONE = 1;
  localparam logic [OFFSET_W-1:0] OFF_ONE = 1;
  localparam logic [INDEX_W-1:0]  IDX_ONE = 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, MREQ, MWAIT, RESP, FLUSH} state_t;
  state_t state_q, state_d;

  logic [ADDR_W-1:0]   addr_q;
  logic [OFFSET_W-1:0] cnt_q;
  logic [INDEX_W-1:0]  fidx_q;
  logic                victim_q;
  logic                hit_q;
  logic [DATA_W-1:0]   word_q;
  logic                resp_valid_q, resp_hit_q;
  logic [DATA_W-1:0]   resp_data_q;
  logic [CNT_W-1:0]    hit_count_q, access_count_q;
  logic [1:0][SETS-1:0] valid_q;
  logic [SETS-1:0]     lru_q;   // per set: the way to evict next

  logic [TAG_W-1:0]  tag_mem  [2][SETS];
  logic [DATA_W-1:0] data_mem [2][SETS*BLK];

  logic [TAG_W-1:0]    tag_a;
  logic [INDEX_W-1:0]  idx_a;
  logic [OFFSET_W-1:0] off_a;
  logic hit0, hit1, hit_any, hit_way, victim_sel, last_word;

  assign tag_a = addr_q[ADDR_W-1 -: TAG_W];
  assign idx_a = addr_q[OFFSET_W +: INDEX_W];
  assign off_a = addr_q[OFFSET_W-1:0];

  assign hit0       = valid_q[0][idx_a] && (tag_mem[0][idx_a] == tag_a);
  assign hit1       = valid_q[1][idx_a] && (tag_mem[1][idx_a] == tag_a);
  assign hit_any    = hit0 || hit1;
  assign hit_way    = ~hit0;
  assign victim_sel = !valid_q[0][idx_a] ? 1'b0 :
                      !valid_q[1][idx_a] ? 1'b1 : lru_q[idx_a];
  assign last_word  = (cnt_q == '1);

  assign bus.req_ready     = (state_q == IDLE) && !flush;
  assign bus.mem_req_valid = (state_q == MREQ);
  assign bus.mem_req_addr  = {tag_a, idx_a, cnt_q};
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.resp_hit      = resp_hit_q;
  assign busy              = (state_q != IDLE);
  assign hit_count         = hit_count_q;
  assign access_count      = access_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (flush) state_d = FLUSH;
               else if (bus.req_valid) state_d = LOOKUP;
      LOOKUP:  state_d = hit_any ? RESP : MREQ;
      MREQ:    if (bus.mem_req_ready) state_d = MWAIT;
      MWAIT:   if (bus.mem_resp_valid) state_d = last_word ? RESP : MREQ;
      RESP:    state_d = IDLE;
      FLUSH:   if (fidx_q == '1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q         <= '0;
      cnt_q          <= '0;
      fidx_q         <= '0;
      victim_q       <= 1'b0;
      hit_q          <= 1'b0;
      word_q         <= '0;
      resp_valid_q   <= 1'b0;
      resp_hit_q     <= 1'b0;
      resp_data_q    <= '0;
      hit_count_q    <= '0;
      access_count_q <= '0;
      valid_q        <= '0;
      lru_q          <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (flush) fidx_q <= '0;
          else if (bus.req_valid) addr_q <= bus.req_addr;
        end
        LOOKUP: begin
          hit_q <= hit_any;
          if (hit_any) begin
            word_q       <= data_mem[hit_way][{idx_a, off_a}];
            lru_q[idx_a] <= ~hit_way;
          end else begin
            victim_q <= victim_sel;
            cnt_q    <= '0;
          end
        end
        MWAIT: begin
          if (bus.mem_resp_valid) begin
            // the requested word may arrive before the last one, so capture it in flight
            if (cnt_q == off_a) word_q <= bus.mem_resp_data;
            if (last_word) begin
              valid_q[victim_q][idx_a] <= 1'b1;
              lru_q[idx_a]             <= ~victim_q;
            end else begin
              cnt_q <= cnt_q + OFF_ONE;
            end
          end
        end
        RESP: begin
          resp_valid_q <= 1'b1;
          resp_data_q  <= word_q;
          resp_hit_q   <= hit_q;
          if (access_count_q != '1) access_count_q <= access_count_q + CNT_ONE;
          if (hit_q && hit_count_q != '1) hit_count_q <= hit_count_q + CNT_ONE;
        end
        FLUSH: begin
          valid_q[0][fidx_q] <= 1'b0;
          valid_q[1][fidx_q] <= 1'b0;
          lru_q[fidx_q]      <= 1'b0;
          fidx_q             <= fidx_q + IDX_ONE;
        end
        default: ;
      endcase
    end
  end

  // Tag/data storage is not reset; validity alone decides what is usable.
  always_ff @(posedge clk) begin
    if (state_q == MWAIT && bus.mem_resp_valid) begin
      data_mem[victim_q][{idx_a, cnt_q}] <= bus.mem_resp_data;
      if (last_word) tag_mem[victim_q][idx_a] <= tag_a;
    end
  end
endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed bench: vector table of reads against a data=address memory model,
// plus hand sequences for flush, reset mid-refill and counter saturation.
module tb_assoc_cache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic busy;
  logic [15:0] hit_count, access_count;
  logic s_flush = 1'b0;
  logic s_busy;
  logic [1:0] s_hit_count, s_access_count;

  always #5 clk = ~clk;

  assoc_cache_ctrl_if #(.ADDR_W(15), .DATA_W(32)) m_if ();
  assoc_cache_ctrl_if #(.ADDR_W(15), .DATA_W(32)) s_if ();

  assoc_cache_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(m_if.slave), .flush(flush), .busy(busy),
    .hit_count(hit_count), .access_count(access_count));

  assoc_cache_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(s_if.slave), .flush(s_flush), .busy(s_busy),
    .hit_count(s_hit_count), .access_count(s_access_count));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Main memory model: data = address, mm_stall idle cycles before each accept.
  logic        mm_en = 1'b1;
  int          mm_stall = 0;
  int          mm_wait = 0;
  logic        mm_pv = 1'b0, mm_pr = 1'b0;
  logic [14:0] mm_pa = '0;
  int          stab_err = 0;
  logic [14:0] req_log[$];

  initial begin
    forever begin
      @(negedge clk);
      if (!mm_en) begin
        mm_pv = 1'b0; mm_pr = 1'b0; mm_wait = 0;
      end else begin
        m_if.mem_resp_valid = 1'b0;
        if (mm_pv && mm_pr) begin
          m_if.mem_resp_valid = 1'b1;
          m_if.mem_resp_data  = 32'(mm_pa);
        end else if (mm_pv && m_if.mem_req_valid && m_if.mem_req_addr != mm_pa) begin
          stab_err++;
        end
        m_if.mem_req_ready = 1'b0;
        if (m_if.mem_req_valid) begin
          if (mm_wait < mm_stall) mm_wait++;
          else begin
            m_if.mem_req_ready = 1'b1;
            mm_wait = 0;
            req_log.push_back(m_if.mem_req_addr);
          end
        end
        mm_pv = m_if.mem_req_valid;
        mm_pr = m_if.mem_req_ready;
        mm_pa = m_if.mem_req_addr;
      end
    end
  end

  // Zero-wait memory for the saturation instance.
  logic        s_pv = 1'b0;
  logic [14:0] s_pa = '0;
  initial begin
    forever begin
      @(negedge clk);
      s_if.mem_resp_valid = s_pv;
      s_if.mem_resp_data  = 32'(s_pa);
      s_pv = s_if.mem_req_valid;
      s_pa = s_if.mem_req_addr;
    end
  end

  task automatic do_read(input logic [14:0] a, output logic [31:0] d,
                         output logic h, output int lat);
    int to;
    @(negedge clk);
    m_if.req_valid = 1'b1;
    m_if.req_addr  = a;
    to = 0;
    while (!m_if.req_ready && to < 50) begin @(negedge clk); to++; end
    @(negedge clk);
    m_if.req_valid = 1'b0;
    lat = 0;
    while (!m_if.resp_valid && lat < 500) begin @(negedge clk); lat++; end
    d = m_if.resp_data;
    h = m_if.resp_hit;
  endtask

  task automatic sat_read(input logic [14:0] a, output logic h);
    int to;
    @(negedge clk);
    s_if.req_valid = 1'b1;
    s_if.req_addr  = a;
    @(negedge clk);
    s_if.req_valid = 1'b0;
    to = 0;
    while (!s_if.resp_valid && to < 100) begin @(negedge clk); to++; end
    h = s_if.resp_hit;
  endtask

  typedef struct {
    logic [14:0] addr;
    int          stall;
    logic [31:0] data;
    logic        hit;
    int          lat;
    int          acc;
    int          hc;
  } vec_t;

  vec_t tv[10];

  initial begin
    logic [31:0] d;
    logic        h;
    int          lat, nb, n0, to;
    logic        rv, ok;

    tv[0] = '{15'h0012, 0, 32'h0012, 1'b0, 10, 1, 0};   // cold miss
    tv[1] = '{15'h0011, 0, 32'h0011, 1'b1,  2, 2, 1};   // hit same line
    tv[2] = '{15'h0010, 0, 32'h0010, 1'b1,  2, 3, 2};
    tv[3] = '{15'h1010, 0, 32'h1010, 1'b0, 10, 4, 2};   // tag 1 -> way 1
    tv[4] = '{15'h0010, 0, 32'h0010, 1'b1,  2, 5, 3};   // tag 0 becomes MRU
    tv[5] = '{15'h2010, 0, 32'h2010, 1'b0, 10, 6, 3};   // evicts tag 1
    tv[6] = '{15'h1010, 0, 32'h1010, 1'b0, 10, 7, 3};   // misses, evicts tag 0
    tv[7] = '{15'h2013, 0, 32'h2013, 1'b1,  2, 8, 4};
    tv[8] = '{15'h0123, 5, 32'h0123, 1'b0, 30, 9, 4};   // backpressured refill
    tv[9] = '{15'h0121, 0, 32'h0121, 1'b1,  2, 10, 5};

    m_if.req_valid = 1'b0; m_if.req_addr = '0;
    m_if.mem_req_ready = 1'b0; m_if.mem_resp_valid = 1'b0; m_if.mem_resp_data = '0;
    s_if.req_valid = 1'b0; s_if.req_addr = '0;
    s_if.mem_req_ready = 1'b1; s_if.mem_resp_valid = 1'b0; s_if.mem_resp_data = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", m_if.resp_valid, 0);
    chk("rst_resp_data", m_if.resp_data, 0);
    chk("rst_resp_hit", m_if.resp_hit, 0);
    chk("rst_mem_req_valid", m_if.mem_req_valid, 0);
    chk("rst_access_count", access_count, 0);
    chk("rst_hit_count", hit_count, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", m_if.req_ready, 1);

    for (int i = 0; i < 10; i++) begin
      mm_stall = tv[i].stall;
      n0 = req_log.size();
      do_read(tv[i].addr, d, h, lat);
      chk($sformatf("v%0d_data", i), d, tv[i].data);
      chk($sformatf("v%0d_hit", i), h, tv[i].hit);
      chk($sformatf("v%0d_latency", i), lat, tv[i].lat);
      chk($sformatf("v%0d_access_count", i), access_count, tv[i].acc);
      chk($sformatf("v%0d_hit_count", i), hit_count, tv[i].hc);
      chk($sformatf("v%0d_mem_reqs", i), req_log.size() - n0, tv[i].hit ? 0 : 4);
      if (!tv[i].hit && req_log.size() - n0 == 4) begin
        ok = 1'b1;
        for (int w = 0; w < 4; w++)
          if (req_log[n0 + w] != {tv[i].addr[14:2], 2'(w)}) ok = 1'b0;
        chk($sformatf("v%0d_mem_order", i), ok, 1);
      end
    end
    mm_stall = 0;
    @(negedge clk);
    chk("resp_single_pulse", m_if.resp_valid, 0);
    chk("mem_addr_stable", stab_err, 0);

    // Flush beats a same-cycle request.
    flush = 1'b1;
    m_if.req_valid = 1'b1;
    m_if.req_addr  = 15'h0011;
    #1 chk("flush_req_ready", m_if.req_ready, 0);
    @(negedge clk);
    m_if.req_valid = 1'b0;
    flush = 1'b0;
    nb = 0; rv = 1'b0;
    while (busy && nb < 3000) begin
      if (m_if.resp_valid) rv = 1'b1;
      nb++;
      @(negedge clk);
    end
    chk("flush_busy_cycles", nb, 1024);
    chk("flush_no_resp", rv, 0);
    chk("flush_access_count", access_count, 10);
    chk("flush_hit_count", hit_count, 5);
    do_read(15'h0011, d, h, lat);
    chk("postflush_hit", h, 0);
    chk("postflush_data", d, 32'h0011);
    chk("postflush_latency", lat, 10);
    chk("postflush_access_count", access_count, 11);

    // Reset while waiting for refill data.
    mm_en = 1'b0;
    @(negedge clk);
    m_if.mem_req_ready = 1'b0; m_if.mem_resp_valid = 1'b0;
    m_if.req_valid = 1'b1; m_if.req_addr = 15'h3010;
    @(negedge clk);
    m_if.req_valid = 1'b0;
    to = 0;
    while (!m_if.mem_req_valid && to < 20) begin @(negedge clk); to++; end
    chk("abort_reached_mreq", m_if.mem_req_valid, 1);
    m_if.mem_req_ready = 1'b1;
    @(negedge clk);
    m_if.mem_req_ready = 1'b0;
    chk("abort_in_mwait_busy", busy, 1);
    chk("abort_in_mwait_no_req", m_if.mem_req_valid, 0);
    rst = 1'b0;
    #1;
    chk("abort_idle", busy, 0);
    chk("abort_access_count", access_count, 0);
    @(negedge clk);
    rst = 1'b1;
    m_if.mem_resp_valid = 1'b1;
    m_if.mem_resp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    m_if.mem_resp_valid = 1'b0;
    chk("stray_resp_ignored", busy, 0);
    mm_en = 1'b1;
    @(negedge clk);
    do_read(15'h3010, d, h, lat);
    chk("abort_line_invalid_hit", h, 0);
    chk("abort_refill_data", d, 32'h3010);
    do_read(15'h3012, d, h, lat);
    chk("abort_then_hit", h, 1);
    chk("abort_then_hit_data", d, 32'h3012);

    // Saturating 2-bit counters: one miss then five hits.
    sat_read(15'h0040, h);
    chk("sat_first_miss", h, 0);
    sat_read(15'h0041, h);
    sat_read(15'h0042, h);
    chk("sat_mid_access", s_access_count, 3);
    chk("sat_mid_hits", s_hit_count, 2);
    for (int k = 0; k < 3; k++) sat_read(15'h0043, h);
    chk("sat_last_hit", h, 1);
    chk("sat_access_count", s_access_count, 3);
    chk("sat_hit_count", s_hit_count, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
